// File: rtl/res_ram_pkg.sv
// Shared constants and arbiter state encoding for the result-RAM arbiter.
package res_ram_pkg;

  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LOCK_MAX   = 15;
  localparam int unsigned LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/res_ram_arb.sv
// Two-master arbiter for the single-port result RAM (m0 = DT engine, m1 = host).
// The owning master gets a combinational grant; ownership moves with fairness and lock rules.
module res_ram_arb #(
  parameter int unsigned ADDR_W   = res_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W   = res_ram_pkg::DATA_W,
  parameter int unsigned LOCK_MAX = res_ram_pkg::LOCK_MAX
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_do,
  input  logic [DATA_W-1:0] ram_di
);

  import res_ram_pkg::*;

  arb_state_e              state_q, state_d;
  logic                    last_id_q, last_id_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                    m0_rvalid_q, m1_rvalid_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       do_q;
  logic                    lock_ok;

  assign lock_ok = (32'(lock_cnt_q) < LOCK_MAX);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    // Address and write data hold their last driven value between accesses.
    ram_addr   = addr_q;
    ram_do     = do_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_id_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        m0_gnt = m0_req;
        if (m0_req) begin
          ram_addr = m0_addr;
          ram_do   = m0_wdata;
          ram_wr   = m0_we;
          ram_rd   = ~m0_we;
        end
        if (m0_req && m0_lock && lock_ok) begin
          state_d    = OWN0;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (m1_req) begin
          state_d = OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        m1_gnt = m1_req;
        if (m1_req) begin
          ram_addr = m1_addr;
          ram_do   = m1_wdata;
          ram_wr   = m1_we;
          ram_rd   = ~m1_we;
        end
        if (m1_req && m1_lock && lock_ok) begin
          state_d    = OWN1;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_id_d = last_id_q;
    if (m0_gnt) begin
      last_id_d = 1'b0;
    end else if (m1_gnt) begin
      last_id_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      addr_q      <= '0;
      do_q        <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= m0_gnt & ~m0_we;
      m1_rvalid_q <= m1_gnt & ~m1_we;
      addr_q      <= ram_addr;
      do_q        <= ram_do;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rvalid_q ? ram_di : '0;
  assign m1_rdata  = m1_rvalid_q ? ram_di : '0;

endmodule
